// File: rtl/fx2_reg_arbiter.sv
// FX2 register interface, clocked: synchronises the FX2 AS/DS/nRDWR strobes,
// owns the 16x16 register file and arbitrates single-word accesses between
// the FX2 host and one internal requester. Register 0 is exported as r0.
module fx2_reg_arbiter #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [15:0] R0_INIT      = 16'h1234,
  parameter logic [15:0] R1_INIT      = 16'h5678
) (
  input  logic        clk,
  input  logic        reset_n,
  inout  wire  [15:0] FX2_data,
  input  logic        FX2_AS,
  input  logic        FX2_DS,
  input  logic        FX2_nRDWR,
  input  logic        int_req,
  input  logic        int_we,
  input  logic [3:0]  int_addr,
  input  logic [15:0] int_wdata,
  output logic        int_gnt,
  output logic [15:0] int_rdata,
  output logic        int_rvalid,
  output logic [15:0] r0,
  output logic        busy
);

  localparam int unsigned    SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, HOST, INT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] as_sync;
  logic [SYNC_STAGES-1:0] ds_sync;
  logic [SYNC_STAGES-1:0] rdwr_sync;
  logic                   as_s, ds_s, rdwr_s;
  logic                   as_d, ds_d;
  logic                   as_rise, ds_rise;

  logic [15:0]            regs [16];
  logic [3:0]             addr_reg;
  logic [15:0]            wdata_lat;
  logic                   host_dir;
  logic                   host_pend;
  logic [15:0]            data_bus;
  logic                   rd_valid;
  logic [SW-1:0]          starve;

  assign as_s    = as_sync[SYNC_STAGES-1];
  assign ds_s    = ds_sync[SYNC_STAGES-1];
  assign rdwr_s  = rdwr_sync[SYNC_STAGES-1];
  assign as_rise = as_s & ~as_d;
  assign ds_rise = ds_s & ~ds_d;

  assign r0   = regs[0];
  assign busy = (state != IDLE) || host_pend;

  // Bus is driven only for a completed host read while the host holds DS;
  // reset_n gates the enable so a reset releases the pins immediately.
  assign FX2_data = (reset_n && rd_valid && ds_s && !rdwr_s) ? data_bus : 'z;

  // Strobe synchronisers and edge-detect flops; free-running so that a strobe
  // held across reset does not produce a spurious edge afterwards.
  always_ff @(posedge clk) begin
    as_sync   <= {as_sync[SYNC_STAGES-2:0], FX2_AS};
    ds_sync   <= {ds_sync[SYNC_STAGES-2:0], FX2_DS};
    rdwr_sync <= {rdwr_sync[SYNC_STAGES-2:0], FX2_nRDWR};
    as_d      <= as_s;
    ds_d      <= ds_s;
  end

  // Arbiter FSM, register file and host/internal datapath.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 16; i++) regs[4'(i)] <= '0;
      regs[0]    <= R0_INIT;
      regs[1]    <= R1_INIT;
      state      <= IDLE;
      addr_reg   <= '0;
      wdata_lat  <= '0;
      host_dir   <= 1'b0;
      host_pend  <= 1'b0;
      data_bus   <= '0;
      rd_valid   <= 1'b0;
      starve     <= '0;
      int_gnt    <= 1'b0;
      int_rdata  <= '0;
      int_rvalid <= 1'b0;
    end else begin
      int_gnt    <= 1'b0;
      int_rvalid <= 1'b0;

      if (as_rise) addr_reg <= FX2_data[3:0];
      if (!ds_s)   rd_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (host_pend && (starve < STARVE_MAX || !int_req)) begin
            state <= HOST;
          end else if (int_req) begin
            state   <= INT;
            int_gnt <= 1'b1;
          end
        end
        HOST: begin
          if (host_dir) begin
            regs[addr_reg] <= wdata_lat;
          end else begin
            data_bus <= regs[addr_reg];
            rd_valid <= 1'b1;
          end
          host_pend <= 1'b0;
          starve    <= int_req ? starve + 1'b1 : '0;
          state     <= IDLE;
        end
        INT: begin
          if (int_we) begin
            regs[int_addr] <= int_wdata;
          end else begin
            int_rdata  <= regs[int_addr];
            int_rvalid <= 1'b1;
          end
          starve <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // The pending slot frees up in the HOST cycle, so an edge landing there
      // re-arms it (overriding the clear above); otherwise edges while pending
      // are dropped.
      if (ds_rise && (!host_pend || state == HOST)) begin
        host_pend <= 1'b1;
        host_dir  <= rdwr_s;
        wdata_lat <= FX2_data;
      end
    end
  end

endmodule

// File: tb/tb_fx2_reg_arbiter.sv
// Directed bench for fx2_reg_arbiter: host and internal accesses, contention,
// same-address collision and reset during a host read.
module tb_fx2_reg_arbiter;

  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fx2_as, fx2_ds, fx2_nrdwr;
  logic        tb_drv;
  logic [15:0] tb_bus;
  wire  [15:0] fx2_data;
  logic        int_req, int_we;
  logic [3:0]  int_addr;
  logic [15:0] int_wdata;
  logic        int_gnt, int_rvalid, busy;
  logic [15:0] int_rdata, r0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          gnt_count = 0;
  int          gnt_j;
  bit          rv_seen;
  logic [15:0] rdata_cap;
  logic [15:0] vals [5];

  assign fx2_data = tb_drv ? tb_bus : 'z;

  fx2_reg_arbiter #(
    .SYNC_STAGES (SYNC),
    .STARVE_LIMIT(4),
    .R0_INIT     (16'h1234),
    .R1_INIT     (16'h5678)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .FX2_data  (fx2_data),
    .FX2_AS    (fx2_as),
    .FX2_DS    (fx2_ds),
    .FX2_nRDWR (fx2_nrdwr),
    .int_req   (int_req),
    .int_we    (int_we),
    .int_addr  (int_addr),
    .int_wdata (int_wdata),
    .int_gnt   (int_gnt),
    .int_rdata (int_rdata),
    .int_rvalid(int_rvalid),
    .r0        (r0),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (int_gnt) gnt_count <= gnt_count + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a probe pattern; it reads back intact only if the DUT is not driving.
  task automatic check_released(input string tag);
    tb_bus = 16'hC3C3;
    tb_drv = 1'b1;
    #1;
    check_val({tag, "_rel"}, fx2_data, 16'hC3C3);
    tb_drv = 1'b0;
  endtask

  task automatic set_addr(input logic [3:0] a);
    @(negedge clk);
    tb_drv = 1'b1;
    tb_bus = {12'h000, a};
    fx2_as = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    fx2_as = 1'b0;
    tb_drv = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [15:0] d);
    set_addr(a);
    @(negedge clk);
    fx2_nrdwr = 1'b1;
    tb_drv    = 1'b1;
    tb_bus    = d;
    fx2_ds    = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    fx2_ds = 1'b0;
    tb_drv = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  // Data must be on the bus at E+2, i.e. the 5th negedge after DS is raised.
  task automatic host_read(input logic [3:0] a, input logic [15:0] exp, input string tag);
    set_addr(a);
    @(negedge clk);
    fx2_nrdwr = 1'b0;
    tb_drv    = 1'b0;
    fx2_ds    = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    check_val(tag, fx2_data, exp);
    fx2_ds = 1'b0;
    repeat (SYNC + 1) @(negedge clk);
    check_released(tag);
  endtask

  task automatic int_access(input logic we, input logic [3:0] a, input logic [15:0] d,
                            input logic [15:0] exp, input string tag);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    int_req   = 1'b1;
    int_we    = we;
    int_addr  = a;
    int_wdata = d;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (int_gnt) begin
        seen    = 1'b1;
        int_req = 1'b0;
      end
    end
    int_req = 1'b0;
    check_val({tag, "_gnt"}, 16'(seen), 16'd1);
    @(posedge clk);
    #1;
    check_val({tag, "_gnt_pulse"}, 16'(int_gnt), 16'd0);
    if (!we) begin
      check_val({tag, "_rvalid"}, 16'(int_rvalid), 16'd1);
      check_val({tag, "_rdata"}, int_rdata, exp);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    fx2_as    = 1'b0;
    fx2_ds    = 1'b0;
    fx2_nrdwr = 1'b0;
    tb_drv    = 1'b0;
    tb_bus    = '0;
    int_req   = 1'b0;
    int_we    = 1'b0;
    int_addr  = '0;
    int_wdata = '0;
    vals      = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005};

    // Reset state
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    check_val("rst_r0", r0, 16'h1234);
    check_val("rst_busy", 16'(busy), 16'd0);
    check_val("rst_int_gnt", 16'(int_gnt), 16'd0);
    check_val("rst_int_rvalid", 16'(int_rvalid), 16'd0);
    check_val("rst_int_rdata", int_rdata, 16'h0000);
    check_released("rst_idle");
    host_read(4'd1, 16'h5678, "rst_rd1");
    host_read(4'd0, 16'h1234, "rst_rd0");
    for (int a = 2; a < 16; a++) host_read(4'(a), 16'h0000, $sformatf("rst_rd%0d", a));

    // Host write then read
    host_write(4'd3, 16'hBEEF);
    host_read(4'd3, 16'hBEEF, "host_rd3");

    // Internal write to register 0, then internal read
    int_access(1'b1, 4'd0, 16'hA5A5, 16'h0000, "int_wr0");
    check_val("int_wr0_r0", r0, 16'hA5A5);
    int_access(1'b0, 4'd0, 16'h0000, 16'hA5A5, "int_rd0");

    // Contention: five back-to-back host writes to reg 7 with int read of reg 7
    // pending; host gets 4 grants (last value 1004), then INT, then host's 5th.
    set_addr(4'd7);
    @(negedge clk);
    fx2_nrdwr = 1'b1;
    int_we    = 1'b0;
    int_addr  = 4'd7;
    gnt_count = 0;
    gnt_j     = -1;
    rv_seen   = 1'b0;
    rdata_cap = '0;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      fx2_ds = (j <= 8) && (j % 2 == 0);
      if (j <= 10 && j % 2 == 0) begin
        tb_drv = 1'b1;
        tb_bus = vals[(j < 2) ? 0 : (j - 2) / 2];
      end
      if (j == 11) tb_drv = 1'b0;
      if (j == 3) int_req = 1'b1;
      @(posedge clk);
      #1;
      if (int_gnt && gnt_j < 0) begin
        gnt_j   = j;
        int_req = 1'b0;
      end
      if (int_rvalid) begin
        rv_seen   = 1'b1;
        rdata_cap = int_rdata;
      end
    end
    int_req = 1'b0;
    tb_drv  = 1'b0;
    check_val("cont_gnt_cycle", 16'(gnt_j), 16'd11);
    check_val("cont_rvalid", 16'(rv_seen), 16'd1);
    check_val("cont_int_rdata", rdata_cap, 16'h1004);
    check_val("cont_gnt_count", 16'(gnt_count), 16'd1);
    host_read(4'd7, 16'h1005, "cont_host_after");

    // Collision: host write 1111 and internal write 2222 to reg 5 together
    set_addr(4'd5);
    @(negedge clk);
    fx2_nrdwr = 1'b1;
    tb_drv    = 1'b1;
    tb_bus    = 16'h1111;
    int_we    = 1'b1;
    int_addr  = 4'd5;
    int_wdata = 16'h2222;
    gnt_j     = -1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      fx2_ds = (j < 6);
      if (j == 6) tb_drv = 1'b0;
      if (j == 3) int_req = 1'b1;
      @(posedge clk);
      #1;
      if (j == 2) check_val("coll_busy_pend", 16'(busy), 16'd1);
      if (int_gnt && gnt_j < 0) begin
        gnt_j   = j;
        int_req = 1'b0;
      end
    end
    int_req = 1'b0;
    tb_drv  = 1'b0;
    check_val("coll_gnt_cycle", 16'(gnt_j), 16'd5);
    host_read(4'd5, 16'h2222, "coll_host_rd5");
    int_access(1'b0, 4'd5, 16'h0000, 16'h2222, "coll_int_rd5");

    // Reset asserted in the HOST cycle of a read of reg 5, DS held high
    set_addr(4'd5);
    @(negedge clk);
    fx2_nrdwr = 1'b0;
    tb_drv    = 1'b0;
    fx2_ds    = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    reset_n = 1'b0;
    check_released("rst_host");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_released("rst_after");
    fx2_ds = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    check_val("rst2_r0", r0, 16'h1234);
    check_val("rst2_busy", 16'(busy), 16'd0);
    host_read(4'd5, 16'h0000, "rst2_rd5");
    host_read(4'd3, 16'h0000, "rst2_rd3");
    host_read(4'd1, 16'h5678, "rst2_rd1");
    int_access(1'b0, 4'd7, 16'h0000, 16'h0000, "rst2_int_rd7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
